vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_timing.sv | 75 +++++++
 rtl/vga_pattern_gen.sv | 100 ++++++++++
 tb/tb_vga_pattern_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480 timing for the VGA pattern generator.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } rgb332_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Each bar-index bit drives one whole colour channel.
  function automatic rgb332_t bar_colour(input logic [2:0] b);
    rgb332_t c;
    c.red   = {3{b[2]}};
    c.green = {3{b[1]}};
    c.blue  = {2{b[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel divider, raster counters, registered sync outputs and frame tick.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pix_en,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [31:0]      h_ext;
  logic [31:0]      v_ext;
  logic             h_last;
  logic             v_last;
  logic             h_in_sync;
  logic             v_in_sync;

  assign h_ext     = 32'(hcount);
  assign v_ext     = 32'(vcount);
  assign pix_en    = (div == DIV_W'(CLK_DIV - 1));
  assign h_last    = (h_ext == 32'(H_TOTAL - 1));
  assign v_last    = (v_ext == 32'(V_TOTAL - 1));
  assign h_in_sync = (h_ext >= 32'(H_ACTIVE + H_FP)) && (h_ext < 32'(H_ACTIVE + H_FP + H_SYNC));
  assign v_in_sync = (v_ext >= 32'(V_ACTIVE + V_FP)) && (v_ext < 32'(V_ACTIVE + V_FP + V_SYNC));
  assign active    = (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));

  // Divider and raster advance; sync is registered from the pixel being consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div        <= '0;
      hcount     <= '0;
      vcount     <= '0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      frame_tick <= 1'b0;
    end else begin
      div        <= pix_en ? '0 : div + 1'b1;
      frame_tick <= pix_en && h_last && v_last;
      if (pix_en) begin
        hsync <= h_in_sync ? SYNC_POL : ~SYNC_POL;
        vsync <= v_in_sync ? SYNC_POL : ~SYNC_POL;
        if (h_last) begin
          hcount <= '0;
          vcount <= v_last ? '0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: solid, colour bars, grid and checkerboard.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit SYNC_POL  = 1'b0,
  parameter int GRID_LOG2 = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic [1:0] mode,
  output logic [2:0] vgaRed,
  output logic [2:0] vgaGreen,
  output logic [2:1] vgaBlue,
  output logic       Hsync,
  output logic       Vsync,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] hcount,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] vcount,
  output logic       frame_tick
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic        pix_en;
  logic        active;
  logic        frame_start;
  mode_e       mode_r;
  mode_e       eff_mode;
  rgb332_t     pat;
  rgb332_t     col_r;
  logic [31:0] bar_full;
  logic [2:0]  bar_idx;
  logic        on_grid;
  logic        checker_odd;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL),
    .HW      (HW),
    .VW      (VW)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_en    (pix_en),
    .hcount    (hcount),
    .vcount    (vcount),
    .active    (active),
    .hsync     (Hsync),
    .vsync     (Vsync),
    .frame_tick(frame_tick)
  );

  assign frame_start = (hcount == '0) && (vcount == '0);

  // Pattern for the pixel at the current counters; the first pixel of a frame already uses the new mode.
  always_comb begin
    eff_mode    = frame_start ? mode_e'(mode) : mode_r;
    bar_full    = (32'(hcount) << 3) / 32'(H_ACTIVE);
    bar_idx     = (bar_full > 32'd7) ? 3'd7 : bar_full[2:0];
    on_grid     = (hcount[GRID_LOG2-1:0] == '0) || (vcount[GRID_LOG2-1:0] == '0);
    checker_odd = hcount[GRID_LOG2] ^ vcount[GRID_LOG2];
    case (eff_mode)
      MODE_SOLID: pat = sw;
      MODE_BARS:  pat = bar_colour(bar_idx);
      MODE_GRID:  pat = on_grid ? 8'hFF : sw;
      MODE_CHECK: pat = checker_odd ? ~sw : sw;
      default:    pat = sw;
    endcase
  end

  // Frame-latched mode and colour output register, both advanced on pixel enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r <= MODE_SOLID;
      col_r  <= '0;
    end else if (pix_en) begin
      if (frame_start) begin
        mode_r <= mode_e'(mode);
      end
      col_r <= active ? pat : 8'h00;
    end
  end

  assign vgaRed   = col_r.red;
  assign vgaGreen = col_r.green;
  assign vgaBlue  = col_r.blue;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen with a small raster and a time-based reference model.
module tb_vga_pattern_gen;

  localparam int D     = 2;
  localparam int H_ACT = 8;
  localparam int HT    = 14;
  localparam int V_ACT = 4;
  localparam int VT    = 8;
  localparam int TOT   = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [1:0] mode = 2'd0;
  logic [2:0] vgaRed, vgaGreen;
  logic [2:1] vgaBlue;
  logic       Hsync, Vsync, frame_tick;
  logic [3:0] hcount;
  logic [2:0] vcount;

  int tests = 0;
  int fails = 0;

  vga_pattern_gen #(
    .CLK_DIV(D),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0),
    .GRID_LOG2(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .Hsync(Hsync), .Vsync(Vsync),
    .hcount(hcount), .vcount(vcount), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_pix(int h, int v, logic [7:0] s, int md);
    int b;
    if (h >= H_ACT || v >= V_ACT) return 8'h00;
    case (md)
      0: return s;
      1: begin
        b = h * 8 / H_ACT;
        return {(b >= 4) ? 3'b111 : 3'b000, ((b / 2) % 2 == 1) ? 3'b111 : 3'b000, (b % 2 == 1) ? 2'b11 : 2'b00};
      end
      2: return (h % 2 == 0 || v % 2 == 0) ? 8'hFF : s;
      default: return (((h / 2) % 2) != ((v / 2) % 2)) ? ~s : s;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: everything follows from the number of clk edges since reset release.
  initial begin
    int n, fmode, q, pos, h, v, cur;
    logic [7:0] e_col;
    logic e_hs, e_vs, e_tick;
    n = 0; fmode = 0; e_col = 8'h00; e_hs = 1'b1; e_vs = 1'b1; e_tick = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        n = 0; e_col = 8'h00; e_hs = 1'b1; e_vs = 1'b1; e_tick = 1'b0;
      end else begin
        n++;
        e_tick = 1'b0;
        if (n % D == 0) begin
          q   = n / D - 1;
          pos = q % TOT;
          h   = pos % HT;
          v   = pos / HT;
          if (pos == 0) fmode = int'(mode);
          e_col  = ref_pix(h, v, sw, fmode);
          e_hs   = !(h >= 10 && h < 13);
          e_vs   = !(v >= 5 && v < 7);
          e_tick = ((q + 1) % TOT == 0);
        end
      end
      cur = (n / D) % TOT;
      #1;
      tests++;
      if ({vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, frame_tick, hcount, vcount} !==
          {e_col, e_hs, e_vs, e_tick, 4'(cur % HT), 3'(cur / HT)}) begin
        fails++;
        $display("FAIL cycle t=%0t: got rgb=%h hs=%b vs=%b tick=%b h=%0d v=%0d, expected rgb=%h hs=%b vs=%b tick=%b h=%0d v=%0d",
                 $time, {vgaRed, vgaGreen, vgaBlue}, Hsync, Vsync, frame_tick, hcount, vcount,
                 e_col, e_hs, e_vs, e_tick, cur % HT, cur / HT);
      end
    end
  end

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_tick) begin ok = 1'b1; break; end
    end
  endtask

  // Output shows pixel (h,v) while the counters sit one position further on.
  task automatic wait_pos(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (int'(hcount) == h + 1 && int'(vcount) == v) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic [1:0] md;
    logic [7:0] s;
    int         h;
    int         v;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    bit ok, prev;
    int cnt;

    tbl.push_back('{2'd0, 8'hE0, 0, 0, 8'hE0});
    tbl.push_back('{2'd0, 8'hE0, 7, 3, 8'hE0});
    tbl.push_back('{2'd0, 8'hE0, 8, 0, 8'h00});
    tbl.push_back('{2'd0, 8'hE0, 2, 5, 8'h00});
    tbl.push_back('{2'd1, 8'h00, 0, 1, 8'h00});
    tbl.push_back('{2'd1, 8'h00, 1, 1, 8'h03});
    tbl.push_back('{2'd1, 8'h00, 2, 1, 8'h1C});
    tbl.push_back('{2'd1, 8'h00, 3, 1, 8'h1F});
    tbl.push_back('{2'd1, 8'h00, 4, 1, 8'hE0});
    tbl.push_back('{2'd1, 8'h00, 5, 1, 8'hE3});
    tbl.push_back('{2'd1, 8'h00, 6, 1, 8'hFC});
    tbl.push_back('{2'd1, 8'h00, 7, 1, 8'hFF});
    tbl.push_back('{2'd2, 8'h25, 1, 1, 8'h25});
    tbl.push_back('{2'd2, 8'h25, 2, 1, 8'hFF});
    tbl.push_back('{2'd2, 8'h25, 1, 2, 8'hFF});
    tbl.push_back('{2'd2, 8'h25, 3, 3, 8'h25});
    tbl.push_back('{2'd2, 8'h25, 9, 1, 8'h00});
    tbl.push_back('{2'd3, 8'h00, 0, 0, 8'h00});
    tbl.push_back('{2'd3, 8'h00, 2, 0, 8'hFF});
    tbl.push_back('{2'd3, 8'h00, 2, 2, 8'h00});
    tbl.push_back('{2'd3, 8'h00, 1, 3, 8'hFF});
    tbl.push_back('{2'd3, 8'h5A, 0, 1, 8'h5A});
    tbl.push_back('{2'd3, 8'h5A, 3, 1, 8'hA5});
    tbl.push_back('{2'd0, 8'h1C, 4, 2, 8'h1C});

    // Reset state and first pixel enable after release.
    sw = 8'hE0; mode = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_state", {vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, frame_tick, hcount, vcount},
          {8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0});
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (hcount == 4'd1) break;
    end
    check("first_enable_clks", cnt, 2);

    // Frame period and number of active red clocks.
    wait_tick(ok);
    check("tick_found", ok, 1);
    cnt = 0;
    begin
      int red_clks, per;
      red_clks = 0; per = 0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        per++;
        if ({vgaRed, vgaGreen, vgaBlue} == 8'hE0) red_clks++;
        if (frame_tick) break;
      end
      check("frame_period", per, 224);
      check("active_red_clks", red_clks, 64);
    end

    // Horizontal sync: start position and width.
    prev = Hsync; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (prev && !Hsync) begin ok = 1'b1; break; end
      prev = Hsync;
    end
    check("hsync_fall", ok, 1);
    check("hsync_start_h", hcount, 11);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Hsync) break;
      cnt++;
    end
    check("hsync_width", cnt, 6);

    // Vertical sync: start position and width.
    prev = Vsync; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (prev && !Vsync) begin ok = 1'b1; break; end
      prev = Vsync;
    end
    check("vsync_fall", ok, 1);
    check("vsync_start_pos", {vcount, hcount}, {3'd5, 4'd1});
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (Vsync) break;
      cnt++;
    end
    check("vsync_width", cnt, 56);

    // Table of single-pixel pattern checks.
    foreach (tbl[k]) begin
      mode = tbl[k].md; sw = tbl[k].s;
      wait_tick(ok);
      check("tbl_tick", ok, 1);
      wait_pos(tbl[k].h, tbl[k].v, ok);
      check("tbl_pos", ok, 1);
      check($sformatf("tbl[%0d]", k), {vgaRed, vgaGreen, vgaBlue}, tbl[k].exp);
    end

    // Mid-frame mode change takes effect only at the next frame.
    mode = 2'd0; sw = 8'hE0;
    wait_tick(ok);
    check("mc_tick", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (vcount == 3'd2) begin ok = 1'b1; break; end
    end
    check("mc_v2", ok, 1);
    mode = 2'd2;
    wait_pos(0, 3, ok);
    check("mc_pos", ok, 1);
    check("mc_same_frame", {vgaRed, vgaGreen, vgaBlue}, 8'hE0);
    wait_tick(ok);
    check("mc_tick2", ok, 1);
    for (int h = 0; h < 4; h++) begin
      wait_pos(h, 1, ok);
      check("mc_pos2", ok, 1);
      check("mc_grid", {vgaRed, vgaGreen, vgaBlue}, (h % 2 == 0) ? 8'hFF : 8'hE0);
    end

    // One-clock reset mid-line.
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hcount == 4'd5) begin ok = 1'b1; break; end
    end
    check("rst_mid_found", ok, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_state", {vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, frame_tick, hcount, vcount},
          {8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0});
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_hold", hcount, 0);
    @(negedge clk);
    check("rst_mid_first", {vcount, hcount}, {3'd0, 4'd1});

    // Randomised run checked cycle by cycle by the reference model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      sw = 8'($urandom);
      if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 699) == 0) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
